// File: rtl/s3g_tx_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// s3g_tx_arbiter_pkg : state encodings and requester indices for the arbiter
// Revision : 1.0
// ============================================================================
package s3g_tx_arbiter_pkg;

    localparam int S3G_MAX_PAYLOAD = 32;

    localparam int REQ_EXEC = 0;
    localparam int REQ_BUF  = 1;
    localparam int REQ_EVT  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/s3g_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// s3g_tx_arbiter_rr_picker : combinational round-robin priority encoder
// Revision : 1.0
// ============================================================================
module s3g_tx_arbiter_rr_picker #(
    parameter int N  = 3,
    parameter int PW = 2
) (
    input  logic [N-1:0]  mask,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic          valid
);

    logic [PW-1:0] w_idx;

    // Scan from ptr upward with wrap; the first set mask bit wins.
    always_comb begin
        onehot = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = PW'((int'(ptr) + i) % N);
            if (!valid && mask[w_idx]) begin
                onehot[w_idx] = 1'b1;
                valid         = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/s3g_tx_arbiter.sv
`default_nettype none
// ============================================================================
// s3g_tx_arbiter : per-packet arbitration of reply sources onto s3g_tx
// Revision : 1.0
// ============================================================================
module s3g_tx_arbiter
    import s3g_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int MAX_LEN = S3G_MAX_PAYLOAD,
    parameter int TIMEOUT = 4095,
    parameter int PRIO0   = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_len,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic [NUM_REQ-1:0]   grant,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_data_valid,
    output logic [NUM_REQ-1:0]   req_data_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_len,
    output logic [7:0]           tx_data,
    output logic                 tx_data_valid,
    input  logic                 tx_data_ready,
    input  logic                 tx_busy,
    output logic                 err_len,
    output logic                 err_timeout,
    output logic                 active
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    arb_state_t r_state, w_state_next;

    logic [NUM_REQ-1:0] r_grant, r_ack;
    logic [PW-1:0]      r_gidx, r_rr;
    logic [7:0]         r_len, r_cnt;
    logic [SW-1:0]      r_stall;
    logic               r_pad, r_err_len, r_err_timeout;

    logic [NUM_REQ-1:0] w_pick_mask, w_pick_onehot;
    logic               w_pick_valid;
    logic [PW-1:0]      w_win_idx;
    logic [7:0]         w_win_len, w_sel_data;
    logic               w_sel_valid, w_decide, w_reject, w_accept;
    logic               w_streaming, w_xfer;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] w);
        if (int'(w) >= NUM_REQ - 1)
            return (PRIO0 != 0) ? PW'(REQ_BUF) : PW'(0);
        return w + PW'(1);
    endfunction

    // With strict priority the exec path masks everyone else out.
    always_comb begin
        w_pick_mask = req_valid;
        if (PRIO0 != 0) begin
            w_pick_mask = req_valid[REQ_EXEC] ? NUM_REQ'(1) : (req_valid & ~NUM_REQ'(1));
        end
    end

    s3g_tx_arbiter_rr_picker #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr_picker (
        .mask   (w_pick_mask),
        .ptr    (r_rr),
        .onehot (w_pick_onehot),
        .valid  (w_pick_valid)
    );

    always_comb begin
        w_win_idx   = '0;
        w_win_len   = '0;
        w_sel_data  = '0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_pick_onehot[i]) begin
                w_win_idx = PW'(i);
                w_win_len = req_len[8*i +: 8];
            end
            if (r_grant[i]) begin
                w_sel_data  = req_data[8*i +: 8];
                w_sel_valid = req_data_valid[i];
            end
        end
    end

    // A pending ack blocks a new decision so a requester still holding
    // req_valid for its ack cycle is not picked twice.
    assign w_decide = (r_state == ST_IDLE) && !tx_busy && (r_ack == '0) && w_pick_valid;
    assign w_reject = w_decide && (w_win_len > 8'(MAX_LEN));
    assign w_accept = w_decide && !w_reject;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_streaming    = (r_state == ST_STREAM);
        tx_start       = (r_state == ST_START);
        tx_data_valid  = w_streaming && (r_pad || w_sel_valid);
        tx_data        = (w_streaming && !r_pad && w_sel_valid) ? w_sel_data : 8'h00;
        req_data_ready = (w_streaming && !r_pad && tx_data_ready) ? (r_grant & req_data_valid) : '0;
        w_xfer         = tx_data_valid && tx_data_ready;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_START;
            ST_START:  w_state_next = (r_len == 8'd0) ? ST_DRAIN : ST_STREAM;
            ST_STREAM: if (w_xfer && (r_cnt + 8'd1 == r_len)) w_state_next = ST_DRAIN;
            ST_DRAIN:  if (!tx_busy) w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_ack         <= '0;
            r_gidx        <= '0;
            r_rr          <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_stall       <= '0;
            r_pad         <= 1'b0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_ack         <= '0;
            r_err_len     <= 1'b0;
            r_err_timeout <= 1'b0;
            if (w_reject) begin
                r_ack     <= w_pick_onehot;
                r_err_len <= 1'b1;
                r_rr      <= f_next_ptr(w_win_idx);
            end
            if (w_accept) begin
                r_ack   <= w_pick_onehot;
                r_grant <= w_pick_onehot;
                r_gidx  <= w_win_idx;
                r_len   <= w_win_len;
                r_cnt   <= '0;
                r_stall <= '0;
                r_pad   <= 1'b0;
            end
            if (w_streaming) begin
                if (w_xfer) begin
                    r_cnt   <= r_cnt + 8'd1;
                    r_stall <= '0;
                end else if (!r_pad && !w_sel_valid) begin
                    // Saturated counter plus one more empty cycle: pad out the frame.
                    if (r_stall == SW'(TIMEOUT)) begin
                        r_pad         <= 1'b1;
                        r_err_timeout <= 1'b1;
                    end else begin
                        r_stall <= r_stall + SW'(1);
                    end
                end
            end
            if ((r_state == ST_DRAIN) && !tx_busy) begin
                r_grant <= '0;
                r_rr    <= f_next_ptr(r_gidx);
                r_len   <= '0;
                r_pad   <= 1'b0;
            end
        end
    end

    assign req_ack     = r_ack;
    assign grant       = r_grant;
    assign tx_len      = r_len;
    assign err_len     = r_err_len;
    assign err_timeout = r_err_timeout;
    assign active      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_s3g_tx_arbiter.sv
`default_nettype none
// ============================================================================
// tb_s3g_tx_arbiter : directed self-checking bench with a simple s3g_tx model
// Revision : 1.0
// ============================================================================
module tb_s3g_tx_arbiter;
    import s3g_tx_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid, req_ack, grant, req_data_valid, req_data_ready;
    logic [7:0]  len_a [3];
    logic [7:0]  dat_a [3];
    logic [23:0] req_len, req_data;
    logic        tx_start, tx_data_valid, tx_data_ready, tx_busy;
    logic        err_len, err_timeout, active;
    logic [7:0]  tx_len, tx_data;
    logic [29:0] outs;

    assign req_len  = {len_a[2], len_a[1], len_a[0]};
    assign req_data = {dat_a[2], dat_a[1], dat_a[0]};
    assign outs = {req_ack, grant, req_data_ready, tx_start, tx_len, tx_data,
                   tx_data_valid, err_len, err_timeout, active};

    s3g_tx_arbiter #(
        .NUM_REQ (3),
        .MAX_LEN (32),
        .TIMEOUT (15),
        .PRIO0   (1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_len        (req_len),
        .req_ack        (req_ack),
        .grant          (grant),
        .req_data       (req_data),
        .req_data_valid (req_data_valid),
        .req_data_ready (req_data_ready),
        .tx_start       (tx_start),
        .tx_len         (tx_len),
        .tx_data        (tx_data),
        .tx_data_valid  (tx_data_valid),
        .tx_data_ready  (tx_data_ready),
        .tx_busy        (tx_busy),
        .err_len        (err_len),
        .err_timeout    (err_timeout),
        .active         (active)
    );

    always #5 clk = ~clk;

    int          n_vec = 0, n_miss = 0;
    int          cyc = 0, n_start, n_err_len, n_err_to, n_take, n_bad_idle = 0;
    int          to_cyc, fall_cyc, busy_drop_cyc, ack_cyc, start_cyc, set_cyc, rem, tail;
    logic        busy_n = 1'b0, rnd_ready = 1'b0, prev_active = 1'b0;
    logic        s_active, any_active;
    logic [29:0] s_outs;
    logic [7:0]  last_len;
    logic [7:0]  rq [3][$];
    logic [7:0]  got [$];
    logic [7:0]  exp_q [$];
    int          got_cyc [$];
    logic [2:0]  got_gnt [$];
    int          ack_order [$];

    task automatic chk_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic chk_got(input string tag);
        chk_eq({tag, "_count"}, got.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < got.size(); k++)
            chk_eq($sformatf("%s_byte%0d", tag, k), got[k], exp_q[k]);
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < 3; i++) begin
            req_data_valid[i] = (rq[i].size() > 0);
            dat_a[i]          = (rq[i].size() > 0) ? rq[i][0] : 8'h00;
        end
    endtask

    task automatic clear_logs();
        got.delete(); got_cyc.delete(); got_gnt.delete(); ack_order.delete(); exp_q.delete();
        n_start = 0; n_err_len = 0; n_err_to = 0; any_active = 1'b0;
        fall_cyc = -1; busy_drop_cyc = -1; to_cyc = -1; ack_cyc = -1; start_cyc = -1;
        set_cyc = cyc;
    endtask

    task automatic post(input int i, input logic [7:0] len, input int nbytes, input logic [7:0] base);
        len_a[i] = len;
        for (int k = 0; k < nbytes; k++) rq[i].push_back(base + 8'(k));
        req_valid[i] = 1'b1;
        drive_reqs();
    endtask

    // One clock: sample everything at negedge, then update inputs just after posedge.
    task automatic cycle();
        logic [2:0] take_v, ack_v;
        @(negedge clk);
        cyc++;
        s_active = active;
        s_outs   = outs;
        if (active) any_active = 1'b1;
        if (!active && tx_busy) n_bad_idle++;
        if (prev_active && !active) fall_cyc = cyc;
        prev_active = active;
        if (tx_start) begin
            n_start++; last_len = tx_len; start_cyc = cyc;
            busy_n = 1'b1; rem = int'(tx_len); tail = 2;
        end else if (busy_n && rem <= 0) begin
            if (tail == 0) begin busy_n = 1'b0; busy_drop_cyc = cyc; end
            else tail--;
        end
        if (tx_data_valid && tx_data_ready) begin
            got.push_back(tx_data); got_cyc.push_back(cyc); got_gnt.push_back(grant); rem--;
        end
        take_v = req_data_ready;
        n_take += $countones(req_data_ready);
        ack_v = req_ack;
        for (int i = 0; i < 3; i++) if (req_ack[i]) begin ack_order.push_back(i); ack_cyc = cyc; end
        if (err_len) n_err_len++;
        if (err_timeout) begin n_err_to++; to_cyc = cyc; end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (take_v[i] && rq[i].size() > 0) void'(rq[i].pop_front());
            if (ack_v[i]) req_valid[i] = 1'b0;
        end
        tx_busy       = busy_n;
        tx_data_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_reqs();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        do begin
            cycle();
            n++;
        end while (!(s_active == 1'b0 && req_valid == 3'b000 && busy_n == 1'b0) && n < budget);
        chk_eq({tag, "_in_budget"}, (n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        req_valid = '0; req_data_valid = '0; tx_data_ready = 1'b1; tx_busy = 1'b0;
        for (int i = 0; i < 3; i++) begin len_a[i] = '0; dat_a[i] = '0; end
        clear_logs();
        cycle(); cycle();
        chk_eq("reset_outs", s_outs, 0);
        rst_n = 1'b1;
        cycle(); cycle();

        // Single exec reply, len 3
        clear_logs();
        len_a[REQ_EXEC] = 8'd3;
        rq[REQ_EXEC].push_back(8'h80); rq[REQ_EXEC].push_back(8'h81); rq[REQ_EXEC].push_back(8'h00);
        req_valid[REQ_EXEC] = 1'b1;
        drive_reqs();
        wait_done("t1", 100);
        exp_q = '{8'h80, 8'h81, 8'h00};
        chk_got("t1_data");
        chk_eq("t1_starts", n_start, 1);
        chk_eq("t1_tx_len", last_len, 3);
        chk_eq("t1_acks", ack_order.size(), 1);
        chk_eq("t1_ack_lat", ack_cyc - set_cyc, 2);
        chk_eq("t1_start_lat", start_cyc - set_cyc, 2);
        chk_eq("t1_first_byte", got_cyc[0] - set_cyc, 3);
        chk_eq("t1_back2back", got_cyc[2] - got_cyc[0], 2);
        chk_eq("t1_grant", got_gnt[0], 3'b001);
        chk_eq("t1_idle_after_busy", fall_cyc - busy_drop_cyc, 2);

        // Simultaneous buf/evt requests, two rounds
        clear_logs();
        post(REQ_BUF, 2, 2, 8'h11); post(REQ_EVT, 2, 2, 8'h21);
        wait_done("t2a", 100);
        chk_eq("t2a_acks", ack_order.size(), 2);
        chk_eq("t2a_first", ack_order[0], 1);
        chk_eq("t2a_second", ack_order[1], 2);
        exp_q = '{8'h11, 8'h12, 8'h21, 8'h22};
        chk_got("t2a_data");
        clear_logs();
        post(REQ_BUF, 2, 2, 8'h15); post(REQ_EVT, 2, 2, 8'h25);
        wait_done("t2b", 100);
        chk_eq("t2b_first", ack_order[0], 1);
        chk_eq("t2b_second", ack_order[1], 2);
        exp_q = '{8'h15, 8'h16, 8'h25, 8'h26};
        chk_got("t2b_data");

        // Exec arrives during a buf packet while evt is also pending
        clear_logs();
        post(REQ_BUF, 4, 4, 8'h41);
        n = 0;
        while (ack_order.size() == 0 && n < 10) begin cycle(); n++; end
        chk_eq("t3_ack_bound", (n < 10), 1);
        post(REQ_EXEC, 1, 1, 8'h51); post(REQ_EVT, 1, 1, 8'h61);
        wait_done("t3", 150);
        chk_eq("t3_acks", ack_order.size(), 3);
        chk_eq("t3_order1", ack_order[1], 0);
        chk_eq("t3_order2", ack_order[2], 2);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h51, 8'h61};
        chk_got("t3_data");
        chk_eq("t3_gnt_mid", got_gnt[3], 3'b010);
        chk_eq("t3_gnt_exec", got_gnt[4], 3'b001);

        // Oversize length rejected
        clear_logs();
        post(REQ_BUF, 8'd40, 0, 8'h00);
        wait_done("t4", 20);
        repeat (3) cycle();
        chk_eq("t4_err_len", n_err_len, 1);
        chk_eq("t4_acks", ack_order.size(), 1);
        chk_eq("t4_no_start", n_start, 0);
        chk_eq("t4_stays_idle", any_active, 0);

        // Zero length and maximum length
        clear_logs();
        post(REQ_EXEC, 8'd0, 0, 8'h00);
        wait_done("t5a", 30);
        chk_eq("t5a_start", n_start, 1);
        chk_eq("t5a_tx_len", last_len, 0);
        chk_eq("t5a_bytes", got.size(), 0);
        clear_logs();
        post(REQ_EVT, 8'd32, 32, 8'hA0);
        wait_done("t5b", 200);
        chk_eq("t5b_tx_len", last_len, 32);
        chk_eq("t5b_err_len", n_err_len, 0);
        for (int k = 0; k < 32; k++) exp_q.push_back(8'hA0 + 8'(k));
        chk_got("t5b_data");

        // Stalled requester, timeout padding
        clear_logs();
        post(REQ_BUF, 8'd4, 2, 8'h31);
        wait_done("t6", 100);
        exp_q = '{8'h31, 8'h32, 8'h00, 8'h00};
        chk_got("t6_data");
        chk_eq("t6_err_to", n_err_to, 1);
        chk_eq("t6_to_delay", to_cyc - got_cyc[1], 17);
        chk_eq("t6_pad_at_to", got_cyc[2], to_cyc);

        // Random backpressure
        clear_logs();
        rnd_ready = 1'b1;
        post(REQ_EXEC, 8'd8, 8, 8'h01);
        wait_done("t7", 300);
        for (int k = 0; k < 8; k++) exp_q.push_back(8'h01 + 8'(k));
        chk_got("t7_data");

        // Reset mid-stream
        clear_logs();
        n_take = 0;
        post(REQ_EVT, 8'd10, 10, 8'hC0);
        n = 0;
        while (got.size() < 4 && n < 200) begin cycle(); n++; end
        chk_eq("t8_stream_bound", (n < 200), 1);
        rst_n = 1'b0;
        busy_n = 1'b0; tx_busy = 1'b0; rem = 0; rnd_ready = 1'b0; tx_data_ready = 1'b1;
        for (int i = 0; i < 3; i++) rq[i].delete();
        req_valid = '0;
        drive_reqs();
        cycle();
        chk_eq("t8_reset_outs", s_outs, 0);
        chk_eq("t8_no_dup_drop", got.size(), n_take);
        for (int k = 0; k < got.size(); k++)
            chk_eq($sformatf("t8_prefix%0d", k), got[k], 8'hC0 + 8'(k));
        rst_n = 1'b1;
        cycle();
        chk_eq("t8_post_reset_outs", s_outs, 0);
        clear_logs();
        post(REQ_BUF, 8'd1, 1, 8'h77);
        wait_done("t8_recover", 50);
        exp_q = '{8'h77};
        chk_got("t8_recover_data");
        chk_eq("t8_recover_ack", ack_order[0], 1);

        chk_eq("active_while_busy", n_bad_idle, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
